// File: rtl/or_unit_rr_arbiter_pkg.sv
// Shared types and defaults for the round-robin OR-unit arbiter.
// Imported by the interface, the picker and the top level.
package or_unit_rr_arbiter_pkg;

   localparam int N_REQ_DEF = 4;
   localparam int WIDTH_DEF = 8;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } slot_st_e;

   function automatic int id_w(int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/or_unit_rr_arbiter_if.sv
// Requester/consumer bundle of the OR-unit arbiter.
// The master side is the operand producers plus the result consumer.
interface or_unit_rr_arbiter_if
   import or_unit_rr_arbiter_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int WIDTH = WIDTH_DEF
);

   localparam int ID_W = id_w(N_REQ);

   logic [N_REQ-1:0]       req_i;
   logic [N_REQ*WIDTH-1:0] a_i;
   logic [N_REQ*WIDTH-1:0] b_i;
   logic [N_REQ-1:0]       gnt_o;
   logic                   res_valid_o;
   logic [WIDTH-1:0]       res_data_o;
   logic [ID_W-1:0]        res_id_o;
   logic                   res_ready_i;

   modport master (
      output req_i,
      output a_i,
      output b_i,
      output res_ready_i,
      input  gnt_o,
      input  res_valid_o,
      input  res_data_o,
      input  res_id_o
   );

   modport slave (
      input  req_i,
      input  a_i,
      input  b_i,
      input  res_ready_i,
      output gnt_o,
      output res_valid_o,
      output res_data_o,
      output res_id_o
   );

endinterface

// File: rtl/or_unit_rr_arbiter_rr_pick.sv
// Round-robin picker: rotate requests by ptr, take the lowest set bit,
// then rotate the offset back into an absolute index and one-hot grant.
module or_unit_rr_arbiter_rr_pick
   import or_unit_rr_arbiter_pkg::*;
#(
   parameter  int N_REQ = N_REQ_DEF,
   localparam int ID_W  = id_w(N_REQ)
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [ID_W-1:0]  i_ptr,
   output logic [N_REQ-1:0] o_gnt,
   output logic [ID_W-1:0]  o_idx
);

   localparam logic [ID_W:0] N_EXT = (ID_W+1)'(N_REQ);

   logic [N_REQ-1:0] w_rot;
   logic [ID_W-1:0]  w_off;
   logic [ID_W:0]    w_sum;

   assign w_rot = N_REQ'({i_req, i_req} >> i_ptr);

   always_comb begin
      w_off = '0;
      for (int k = N_REQ-1; k >= 0; k--) begin
         if (w_rot[k]) w_off = ID_W'(k);
      end
   end

   always_comb begin
      w_sum = {1'b0, i_ptr} + {1'b0, w_off};
      if (w_sum >= N_EXT) w_sum = w_sum - N_EXT;
   end

   assign o_idx = w_sum[ID_W-1:0];
   assign o_gnt = (|i_req) ? (N_REQ'(1) << o_idx) : '0;

endmodule

// File: rtl/or_unit_rr_arbiter.sv
// Round-robin scheduler for one shared registered OR datapath,
// with a single result slot under valid/ready back-pressure.
module or_unit_rr_arbiter
   import or_unit_rr_arbiter_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   or_unit_rr_arbiter_if.slave bus
);

   localparam int ID_W = id_w(N_REQ);

   slot_st_e         r_state;
   logic [WIDTH-1:0] r_data;
   logic [ID_W-1:0]  r_id;
   logic [ID_W-1:0]  r_ptr;

   logic             w_slot_free;
   logic             w_xfer;
   logic [N_REQ-1:0] w_gnt;
   logic [ID_W-1:0]  w_idx;
   logic [ID_W-1:0]  w_ptr_nxt;
   logic [WIDTH-1:0] w_a;
   logic [WIDTH-1:0] w_b;
   logic [WIDTH-1:0] w_y;

   or_unit_rr_arbiter_rr_pick #(
      .N_REQ (N_REQ)
   ) u_pick (
      .i_req (bus.req_i),
      .i_ptr (r_ptr),
      .o_gnt (w_gnt),
      .o_idx (w_idx)
   );

   assign w_slot_free = (r_state == ST_EMPTY) || bus.res_ready_i;
   assign w_xfer      = w_slot_free && (|bus.req_i);

   // Only the granted slice reaches the OR, so idle operands never leak.
   assign w_a = bus.a_i[int'(w_idx)*WIDTH +: WIDTH];
   assign w_b = bus.b_i[int'(w_idx)*WIDTH +: WIDTH];
   assign w_y = w_a | w_b;

   assign w_ptr_nxt = (w_idx == ID_W'(N_REQ-1)) ? '0 : w_idx + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_EMPTY;
         r_data  <= '0;
         r_id    <= '0;
         r_ptr   <= '0;
      end else if (w_xfer) begin
         r_state <= ST_FULL;
         r_data  <= w_y;
         r_id    <= w_idx;
         r_ptr   <= w_ptr_nxt;
      end else if (r_state == ST_FULL && bus.res_ready_i) begin
         r_state <= ST_EMPTY;
      end
   end

   assign bus.gnt_o       = (rst_n && w_slot_free) ? w_gnt : '0;
   assign bus.res_valid_o = (r_state == ST_FULL);
   assign bus.res_data_o  = r_data;
   assign bus.res_id_o    = r_id;

endmodule

// File: tb/tb_or_unit_rr_arbiter.sv
// Bench for or_unit_rr_arbiter: directed scenarios plus randomized
// traffic checked against a behavioural round-robin model.
module tb_or_unit_rr_arbiter;

   localparam int N = 4;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   or_unit_rr_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

   or_unit_rr_arbiter #(
      .N_REQ (N),
      .WIDTH (W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int         checks = 0;
   int         errors = 0;
   int         m_ptr;
   int         m_id;
   int         m_last;
   bit         m_valid;
   logic [7:0] m_data;
   logic [7:0] op_a [N];
   logic [7:0] op_b [N];

   function automatic logic [N-1:0] exp_gnt(logic [N-1:0] req, logic rdy);
      logic [N-1:0] g;
      g = '0;
      if (m_valid && !rdy) return g;
      for (int i = 0; i < N; i++) begin
         if (req[(m_ptr + i) % N]) begin
            g[(m_ptr + i) % N] = 1'b1;
            return g;
         end
      end
      return g;
   endfunction

   task automatic model_reset();
      m_ptr = 0;
      m_id = 0;
      m_valid = 0;
      m_data = '0;
      m_last = -1;
   endtask

   task automatic pack_ops(logic [N-1:0] req);
      for (int k = 0; k < N; k++) begin
         bus.a_i[k*W +: W] = req[k] ? op_a[k] : {W{1'bx}};
         bus.b_i[k*W +: W] = req[k] ? op_b[k] : {W{1'bx}};
      end
   endtask

   task automatic new_ops(int k);
      op_a[k] = 8'($urandom);
      op_b[k] = 8'($urandom);
   endtask

   task automatic advance();
      logic [N-1:0] g;
      @(posedge clk);
      m_last = -1;
      if (rst_n) begin
         g = exp_gnt(bus.req_i, bus.res_ready_i);
         for (int k = 0; k < N; k++) if (g[k]) m_last = k;
         if (m_last >= 0) begin
            m_data = op_a[m_last] | op_b[m_last];
            m_id = m_last;
            m_valid = 1;
            m_ptr = (m_last + 1) % N;
         end else if (m_valid && bus.res_ready_i) begin
            m_valid = 0;
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.req_i = 4'b1111;
      bus.res_ready_i = 1'b1;
      for (int k = 0; k < N; k++) new_ops(k);
      pack_ops(bus.req_i);
      model_reset();
      #1;
      checks++;
      if (bus.gnt_o !== 4'b0000) begin
         errors++;
         $display("FAIL reset_gnt: got %b expected 0000", bus.gnt_o);
      end
      checks++;
      if (bus.res_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_valid: got %b expected 0", bus.res_valid_o);
      end
      checks++;
      if (bus.res_data_o !== 8'h00) begin
         errors++;
         $display("FAIL reset_data: got %h expected 00", bus.res_data_o);
      end
      checks++;
      if (bus.res_id_o !== 2'd0) begin
         errors++;
         $display("FAIL reset_id: got %0d expected 0", bus.res_id_o);
      end
      repeat (2) advance();
      rst_n = 1'b1;
      #1;
      checks++;
      if (bus.gnt_o !== 4'b0001) begin
         errors++;
         $display("FAIL first_grant: got %b expected 0001", bus.gnt_o);
      end
      bus.req_i = '0;
      pack_ops(bus.req_i);
      advance();
   endtask

   task automatic test_single();
      op_a[2] = 8'hA0;
      op_b[2] = 8'h0C;
      bus.req_i = 4'b0100;
      bus.res_ready_i = 1'b1;
      pack_ops(bus.req_i);
      #1;
      checks++;
      if (bus.gnt_o !== 4'b0100) begin
         errors++;
         $display("FAIL single_gnt: got %b expected 0100", bus.gnt_o);
      end
      advance();
      bus.req_i = '0;
      pack_ops(bus.req_i);
      #1;
      checks++;
      if (bus.res_valid_o !== 1'b1 || bus.res_data_o !== 8'hAC ||
          bus.res_id_o !== 2'd2) begin
         errors++;
         $display("FAIL single_res: got v=%b d=%h id=%0d expected v=1 d=ac id=2",
                  bus.res_valid_o, bus.res_data_o, bus.res_id_o);
      end
      advance();
      checks++;
      if (bus.res_valid_o !== 1'b0 || bus.res_data_o !== 8'hAC) begin
         errors++;
         $display("FAIL single_drain: got v=%b d=%h expected v=0 d=ac",
                  bus.res_valid_o, bus.res_data_o);
      end
   endtask

   task automatic test_wrap_skip();
      logic [3:0] exp_g [3];
      exp_g[0] = 4'b0001;
      exp_g[1] = 4'b0010;
      exp_g[2] = 4'b0001;
      new_ops(0);
      new_ops(1);
      bus.req_i = 4'b0011;
      bus.res_ready_i = 1'b1;
      pack_ops(bus.req_i);
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (bus.gnt_o !== exp_g[i]) begin
            errors++;
            $display("FAIL wrap_gnt%0d: got %b expected %b", i, bus.gnt_o, exp_g[i]);
         end
         if (i > 0) begin
            checks++;
            if (bus.res_id_o !== 2'(i - 1)) begin
               errors++;
               $display("FAIL wrap_id%0d: got %0d expected %0d", i, bus.res_id_o, i - 1);
            end
         end
         advance();
      end
      bus.req_i = '0;
      pack_ops(bus.req_i);
      #1;
      checks++;
      if (bus.res_id_o !== 2'd0 || bus.res_data_o !== (op_a[0] | op_b[0])) begin
         errors++;
         $display("FAIL wrap_last: got id=%0d d=%h expected id=0 d=%h",
                  bus.res_id_o, bus.res_data_o, op_a[0] | op_b[0]);
      end
      advance();
   endtask

   task automatic test_round_robin();
      logic [3:0] e;
      int         pid;
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      model_reset();
      for (int k = 0; k < N; k++) new_ops(k);
      bus.req_i = 4'b1111;
      bus.res_ready_i = 1'b1;
      pack_ops(bus.req_i);
      for (int i = 0; i < 5; i++) begin
         #1;
         e = 4'(1 << (i % N));
         checks++;
         if (bus.gnt_o !== e) begin
            errors++;
            $display("FAIL rr_gnt%0d: got %b expected %b", i, bus.gnt_o, e);
         end
         if (i > 0) begin
            pid = (i - 1) % N;
            checks++;
            if (bus.res_valid_o !== 1'b1 || bus.res_id_o !== 2'(pid) ||
                bus.res_data_o !== (op_a[pid] | op_b[pid])) begin
               errors++;
               $display("FAIL rr_res%0d: got v=%b id=%0d d=%h expected v=1 id=%0d d=%h",
                        i, bus.res_valid_o, bus.res_id_o, bus.res_data_o,
                        pid, op_a[pid] | op_b[pid]);
            end
         end
         advance();
      end
      bus.req_i = '0;
      pack_ops(bus.req_i);
      #1;
      checks++;
      if (bus.res_valid_o !== 1'b1 || bus.res_id_o !== 2'd0) begin
         errors++;
         $display("FAIL rr_last: got v=%b id=%0d expected v=1 id=0",
                  bus.res_valid_o, bus.res_id_o);
      end
      advance();
   endtask

   task automatic test_backpressure();
      logic [7:0] d0;
      new_ops(0);
      bus.req_i = 4'b0001;
      bus.res_ready_i = 1'b1;
      pack_ops(bus.req_i);
      #1;
      checks++;
      if (bus.gnt_o !== 4'b0001) begin
         errors++;
         $display("FAIL bp_pre_gnt: got %b expected 0001", bus.gnt_o);
      end
      advance();
      d0 = op_a[0] | op_b[0];
      new_ops(1);
      bus.req_i = 4'b0010;
      bus.res_ready_i = 1'b0;
      pack_ops(bus.req_i);
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (bus.gnt_o !== 4'b0000 || bus.res_valid_o !== 1'b1 ||
             bus.res_data_o !== d0 || bus.res_id_o !== 2'd0) begin
            errors++;
            $display("FAIL bp_stall%0d: got g=%b v=%b d=%h id=%0d expected g=0000 v=1 d=%h id=0",
                     i, bus.gnt_o, bus.res_valid_o, bus.res_data_o, bus.res_id_o, d0);
         end
         advance();
      end
      bus.res_ready_i = 1'b1;
      #1;
      checks++;
      if (bus.gnt_o !== 4'b0010) begin
         errors++;
         $display("FAIL bp_release_gnt: got %b expected 0010", bus.gnt_o);
      end
      advance();
      bus.req_i = '0;
      bus.res_ready_i = 1'b0;
      pack_ops(bus.req_i);
      #1;
      checks++;
      if (bus.res_valid_o !== 1'b1 || bus.res_id_o !== 2'd1 ||
          bus.res_data_o !== (op_a[1] | op_b[1])) begin
         errors++;
         $display("FAIL bp_overwrite: got v=%b id=%0d d=%h expected v=1 id=1 d=%h",
                  bus.res_valid_o, bus.res_id_o, bus.res_data_o, op_a[1] | op_b[1]);
      end
   endtask

   task automatic test_async_reset();
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.res_valid_o !== 1'b0 || bus.gnt_o !== 4'b0000 ||
          bus.res_data_o !== 8'h00) begin
         errors++;
         $display("FAIL async_rst: got v=%b g=%b d=%h expected v=0 g=0000 d=00",
                  bus.res_valid_o, bus.gnt_o, bus.res_data_o);
      end
      #1;
      rst_n = 1'b1;
      model_reset();
      advance();
      for (int k = 0; k < N; k++) new_ops(k);
      bus.req_i = 4'b1111;
      bus.res_ready_i = 1'b1;
      pack_ops(bus.req_i);
      #1;
      checks++;
      if (bus.gnt_o !== 4'b0001) begin
         errors++;
         $display("FAIL async_ptr: got %b expected 0001", bus.gnt_o);
      end
      advance();
      bus.req_i = '0;
      pack_ops(bus.req_i);
      advance();
   endtask

   task automatic test_random();
      logic [N-1:0] pend;
      logic [N-1:0] e;
      logic [N-1:0] obs;
      int           wt [N];
      pend = '0;
      for (int k = 0; k < N; k++) wt[k] = 0;
      repeat (400) begin
         for (int k = 0; k < N; k++) begin
            if (!pend[k] && ($urandom % 3 != 0)) begin
               pend[k] = 1'b1;
               new_ops(k);
               wt[k] = 0;
            end
         end
         bus.req_i = pend;
         bus.res_ready_i = ($urandom % 4 != 0);
         pack_ops(pend);
         #1;
         e = exp_gnt(pend, bus.res_ready_i);
         obs = bus.gnt_o;
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL rnd_gnt: got %b expected %b", obs, e);
         end
         checks++;
         if (bus.res_valid_o !== m_valid || bus.res_data_o !== m_data ||
             bus.res_id_o !== 2'(m_id)) begin
            errors++;
            $display("FAIL rnd_res: got v=%b d=%h id=%0d expected v=%b d=%h id=%0d",
                     bus.res_valid_o, bus.res_data_o, bus.res_id_o,
                     m_valid, m_data, m_id);
         end
         advance();
         if (m_last >= 0) pend[m_last] = 1'b0;
         if (|obs) begin
            for (int k = 0; k < N; k++) begin
               if (pend[k] && !obs[k]) begin
                  wt[k]++;
                  checks++;
                  if (wt[k] > N - 1) begin
                     errors++;
                     $display("FAIL rnd_starve: req %0d waited %0d transfers expected <= %0d",
                              k, wt[k], N - 1);
                  end
               end
            end
         end
      end
      bus.req_i = '0;
      pack_ops(bus.req_i);
   endtask

   initial begin
      bus.req_i = '0;
      bus.a_i = '0;
      bus.b_i = '0;
      bus.res_ready_i = 1'b1;
      model_reset();
      @(negedge clk);
      test_reset();
      test_single();
      test_wrap_skip();
      test_round_robin();
      test_backpressure();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
